// File: rtl/aes_spi_master_pkg.sv
// Shared definitions for the AES SPI initiator and its accelerator-side bench model.
// Holds the controller state encoding and the load/read frame lengths.
// No logic lives here; importers size their counters from these constants.
package aes_spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_GAP,
      ST_WAIT_DONE,
      ST_READ,
      ST_FIN
   } state_t;

   // {key, plaintext} shifted out per request
   localparam int LOAD_BITS = 256;
   // cyphertext bits clocked back per request
   localparam int READ_BITS = 128;

endpackage

// File: rtl/aes_spi_master_sync2.sv
// Generic two-flop synchronizer for a single asynchronous level.
// Latency: two clk cycles from input change to output change.
// No handshake; the input is assumed to be slow compared with clk.
module sync2 (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_d,
   output logic o_q
);

   logic r_ff1;
   logic r_ff2;

   // two-stage capture of the asynchronous level
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_ff1 <= 1'b0;
         r_ff2 <= 1'b0;
      end else begin
         r_ff1 <= i_d;
         r_ff2 <= r_ff1;
      end
   end

   assign o_q = r_ff2;

endmodule

// File: rtl/aes_spi_master.sv
// SPI initiator: loads key+plaintext into the AES accelerator, waits for done, reads cyphertext.
// Latency: 512*CLK_DIV load + CLK_DIV gap + done wait + 256*CLK_DIV read + 1 cycle to valid.
// Requests arriving while busy are dropped; a missing done aborts with a one-cycle err.
module aes_spi_master
   import aes_spi_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int TIMEOUT = 65535
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_start,
   input  logic [127:0] i_key,
   input  logic [127:0] i_plaintext,
   output logic         o_busy,
   output logic         o_valid,
   output logic         o_err,
   output logic [127:0] o_cyphertext,
   output logic         o_sclk,
   output logic         o_mosi,
   output logic         o_ce,
   input  logic         i_miso,
   input  logic         i_done_in
);

   localparam int DIV_W = $clog2(2 * CLK_DIV);
   localparam int TO_W  = $clog2(TIMEOUT + 1);

   // one sclk period is 2*CLK_DIV clk cycles: low half first, then high half
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(2 * CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HI    = DIV_W'(CLK_DIV);
   localparam logic [DIV_W-1:0] GAP_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(TIMEOUT);
   localparam logic [8:0]       LOAD_LAST = 9'(LOAD_BITS - 1);
   localparam logic [8:0]       READ_LAST = 9'(READ_BITS - 1);

   state_t             r_state;
   state_t             w_next;
   logic [DIV_W-1:0]   r_div;
   logic [8:0]         r_bit;
   logic [TO_W-1:0]    r_to;
   logic [255:0]       r_sh;
   logic [127:0]       r_res;
   logic [127:0]       r_cyph;
   logic               w_done_s;
   logic               w_miso_s;
   logic               w_bit_end;

   sync2 u_sync_done (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_d     (i_done_in),
      .o_q     (w_done_s)
   );

   sync2 u_sync_miso (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_d     (i_miso),
      .o_q     (w_miso_s)
   );

   assign w_bit_end    = (r_div == DIV_LAST);
   assign o_cyphertext = r_cyph;

   // state register
   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= ST_IDLE;
      else         r_state <= w_next;
   end

   // next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:      if (i_start) w_next = ST_LOAD;
         ST_LOAD:      if (w_bit_end && (r_bit == LOAD_LAST)) w_next = ST_GAP;
         ST_GAP:       if (r_div == GAP_LAST) w_next = ST_WAIT_DONE;
         ST_WAIT_DONE: if (w_done_s) w_next = ST_READ;
                       else if (r_to == TO_MAX) w_next = ST_IDLE;
         ST_READ:      if (w_bit_end && (r_bit == READ_LAST)) w_next = ST_FIN;
         ST_FIN:       w_next = ST_IDLE;
         default:      w_next = ST_IDLE;
      endcase
   end

   // counters, load shifter and result capture; counters restart on every state change
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_div  <= '0;
         r_bit  <= '0;
         r_to   <= '0;
         r_sh   <= '0;
         r_res  <= '0;
         r_cyph <= '0;
      end else begin
         r_to <= (r_state == ST_WAIT_DONE) ? r_to + 1'b1 : '0;

         if (r_state != w_next) begin
            r_div <= '0;
            r_bit <= '0;
         end else if (r_state inside {ST_LOAD, ST_GAP, ST_READ}) begin
            r_div <= w_bit_end ? '0 : r_div + 1'b1;
            if (w_bit_end) r_bit <= r_bit + 1'b1;
         end

         // mosi is r_sh[255]; it advances only at a bit boundary, so it is stable across sclk rise
         if ((r_state == ST_IDLE) && i_start)
            r_sh <= {i_key, i_plaintext};
         else if ((r_state == ST_LOAD) && w_bit_end)
            r_sh <= {r_sh[254:0], 1'b0};

         // miso sampled the cycle sclk goes high; first bit ends up in bit 127
         if ((r_state == ST_READ) && (r_div == DIV_HI))
            r_res <= {r_res[126:0], w_miso_s};

         if ((r_state == ST_READ) && (w_next == ST_FIN))
            r_cyph <= r_res;
      end
   end

   // pin and status outputs decoded from state and phase
   always_comb begin
      o_ce    = (r_state == ST_LOAD) || (r_state == ST_GAP);
      o_sclk  = ((r_state == ST_LOAD) || (r_state == ST_READ)) && (r_div >= DIV_HI);
      o_mosi  = (r_state == ST_LOAD) ? r_sh[255] : 1'b0;
      o_busy  = (r_state != ST_IDLE);
      o_valid = (r_state == ST_FIN);
      o_err   = (r_state == ST_WAIT_DONE) && !w_done_s && (r_to == TO_MAX);
   end

endmodule

// File: tb/tb_aes_spi_master.sv
// Directed bench for aes_spi_master with a behavioural accelerator on the SPI pins.
// Table vectors run back to back; hand sequences cover timeout, start spam and mid-load reset.
// Every wait is bounded and an expired bound is reported as a failed check.
module tb_aes_spi_master;
   import aes_spi_pkg::*;

   localparam int CLK_DIV = 4;
   localparam int TIMEOUT = 100;
   localparam int BOUND   = 6000;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [127:0] key = '0;
   logic [127:0] plaintext = '0;
   logic         busy, valid, err;
   logic [127:0] cyphertext;
   logic         sclk, mosi, ce;
   logic         miso = 1'b0;
   logic         done_in = 1'b0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   aes_spi_master #(.CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT)) dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_start      (start),
      .i_key        (key),
      .i_plaintext  (plaintext),
      .o_busy       (busy),
      .o_valid      (valid),
      .o_err        (err),
      .o_cyphertext (cyphertext),
      .o_sclk       (sclk),
      .o_mosi       (mosi),
      .o_ce         (ce),
      .i_miso       (miso),
      .i_done_in    (done_in)
   );

   // ---------------- accelerator model ----------------
   logic         prev_sclk = 1'b0, prev_ce = 1'b0, prev_mosi = 1'b0;
   logic [255:0] ld_sh = '0;
   logic [127:0] res_sh = '0;
   int ld_cnt = 0, rd_cnt = 0, ce_rises = 0, valid_cnt = 0, err_cnt = 0, viol = 0;
   int done_timer = 0, ce_rise_cyc = 0, ce_fall_cyc = 0, first_rise_cyc = -1;
   bit no_done = 1'b0;

   function automatic logic [127:0] accel_f(input logic [127:0] k, input logic [127:0] p);
      if (k == 128'h000102030405060708090a0b0c0d0e0f && p == 128'h00112233445566778899aabbccddeeff)
         return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      return k ^ {p[63:0], p[127:64]};
   endfunction

   always @(negedge clk) begin
      if (reset) begin
         ld_cnt = 0; done_in = 1'b0; done_timer = 0; miso = 1'b0;
      end else begin
         if (ce && !prev_ce) begin
            ce_rises++; ce_rise_cyc = cyc; ld_cnt = 0; rd_cnt = 0; first_rise_cyc = -1;
         end
         if (!ce && prev_ce) begin
            ce_fall_cyc = cyc;
            if (ld_cnt == LOAD_BITS) begin
               res_sh = accel_f(ld_sh[255:128], ld_sh[127:0]);
               if (!no_done) done_timer = 20;
            end
         end
         if (sclk && !prev_sclk) begin
            if (ce) begin
               if (mosi !== prev_mosi) viol++;
               ld_sh = {ld_sh[254:0], mosi};
               ld_cnt++;
               if (first_rise_cyc < 0) first_rise_cyc = cyc;
            end else begin
               rd_cnt++;
               done_in = 1'b0;
            end
         end
         if (!sclk && prev_sclk && !ce) begin
            res_sh = {res_sh[126:0], 1'b0};
            miso = res_sh[127];
         end
         if (done_timer > 0) begin
            done_timer--;
            if (done_timer == 0) begin
               done_in = 1'b1;
               miso = res_sh[127];
            end
         end
         if (valid) valid_cnt++;
         if (err) err_cnt++;
      end
      prev_sclk = sclk; prev_ce = ce; prev_mosi = mosi;
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic wait_idle;
      int n = 0;
      while (busy && n < BOUND) begin tick; n++; end
      if (busy) check("busy_bound", 1'b1, 1'b0);
   endtask

   task automatic run_txn(input string tag, input logic [127:0] k, input logic [127:0] p,
                          input logic [127:0] exp);
      int t0;
      int n;
      wait_idle;
      key = k; plaintext = p; start = 1'b1; t0 = cyc;
      valid_cnt = 0; viol = 0;
      tick;
      start = 1'b0;
      n = 0;
      while (!valid && n < BOUND) begin tick; n++; end
      if (!valid) check({tag, "_valid_bound"}, 1'b0, 1'b1);
      check({tag, "_cyphertext"}, cyphertext, exp);
      tick;
      check({tag, "_busy_after_valid"}, busy, 1'b0);
      check({tag, "_valid_pulses"}, valid_cnt, 1);
      check({tag, "_load_rises"}, ld_cnt, LOAD_BITS);
      check({tag, "_read_rises"}, rd_cnt, READ_BITS);
      check({tag, "_mosi_unstable"}, viol, 0);
      check({tag, "_ce_rise_cyc"}, ce_rise_cyc - t0, 1);
      check({tag, "_first_sclk_cyc"}, first_rise_cyc - t0, 1 + CLK_DIV);
      check({tag, "_ce_fall_cyc"}, ce_fall_cyc - (t0 + 1), 2 * LOAD_BITS * CLK_DIV + CLK_DIV);
   endtask

   typedef struct {
      logic [127:0] key;
      logic [127:0] pt;
      logic [127:0] exp;
   } vec_t;

   vec_t vecs[4];

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] held_ct;
      int n;

      vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
      vecs[1] = '{128'h0, 128'haaaaaaaaaaaaaaaa5555555555555555,
                  128'h5555555555555555aaaaaaaaaaaaaaaa};
      vecs[2] = '{128'hffffffffffffffffffffffffffffffff, 128'h0,
                  128'hffffffffffffffffffffffffffffffff};
      vecs[3] = '{128'h0123456789abcdeffedcba9876543210, 128'h11111111111111110000000000000000,
                  128'h0123456789abcdefefcdab8967452301};

      // reset values
      repeat (3) tick;
      check("reset_pins", {sclk, mosi, ce, busy, valid, err}, 6'b0);
      check("reset_cyphertext", cyphertext, 128'h0);
      reset = 1'b0;
      tick;

      // table vectors, each issued as soon as busy falls
      foreach (vecs[i]) run_txn($sformatf("vec%0d", i), vecs[i].key, vecs[i].pt, vecs[i].exp);

      // done never arrives -> err after TIMEOUT cycles in WAIT_DONE
      no_done = 1'b1;
      held_ct = cyphertext;
      valid_cnt = 0; err_cnt = 0;
      key = vecs[1].key; plaintext = vecs[1].pt; start = 1'b1;
      tick;
      start = 1'b0;
      n = 0;
      while (!err && n < BOUND) begin tick; n++; end
      if (!err) check("timeout_err_bound", 1'b0, 1'b1);
      check("timeout_err_delay", cyc - ce_fall_cyc, TIMEOUT);
      check("timeout_cyphertext_held", cyphertext, held_ct);
      tick;
      check("timeout_busy_next", busy, 1'b0);
      check("timeout_err_one_cycle", err, 1'b0);
      check("timeout_err_pulses", err_cnt, 1);
      check("timeout_no_valid", valid_cnt, 0);
      no_done = 1'b0;

      // start held high for the whole transfer -> one transaction only
      valid_cnt = 0; ce_rises = 0;
      key = vecs[3].key; plaintext = vecs[3].pt; start = 1'b1;
      n = 0;
      while (!valid && n < BOUND) begin tick; n++; end
      start = 1'b0;
      if (!valid) check("spam_valid_bound", 1'b0, 1'b1);
      check("spam_cyphertext", cyphertext, vecs[3].exp);
      tick;
      check("spam_single_load", ce_rises, 1);
      check("spam_valid_pulses", valid_cnt, 1);
      run_txn("after_spam", vecs[2].key, vecs[2].pt, vecs[2].exp);

      // reset in the middle of the load frame
      key = vecs[1].key; plaintext = vecs[1].pt; start = 1'b1;
      tick;
      start = 1'b0;
      n = 0;
      while (ld_cnt != 100 && n < BOUND) begin tick; n++; end
      if (ld_cnt != 100) check("midreset_bound", ld_cnt, 100);
      reset = 1'b1;
      tick;
      check("midreset_pins", {sclk, ce, mosi, busy}, 4'b0);
      check("midreset_cyphertext", cyphertext, 128'h0);
      reset = 1'b0;
      tick;
      run_txn("after_reset", vecs[0].key, vecs[0].pt, vecs[0].exp);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
